seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receiving end of the multiplexed seven-segment display interface. Samples a scanned bus
//  (one-hot digit select + active-low segment lines) and filters each digit for stability.
//  Decodes every segment pattern back to BCD and assembles NUM_DIGITS digits into one frame.
//  The frame is presented with a valid/ready handshake. Used for on-board loopback checking
//  of display drivers, and as the input stage for segment-coded data.
// PARAMETERS
//  NUM_DIGITS     4  digits per frame; slot i <-> dig_sel[i] <-> out_bcd[4i+3:4i]
//  STABLE_CYCLES  4  consecutive identical samples required to accept a digit (>=2)
//  CNT_W          3  stability counter width; must hold STABLE_CYCLES
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_n      in   1              synchronous reset, active low
//  seg_in     in   7              segment lines gfedcba, bit0=a, active low (0=lit)
//  dig_sel    in   NUM_DIGITS     digit enable, one-hot, active high
//  out_bcd    out  4*NUM_DIGITS   decoded frame
//  out_blank  out  NUM_DIGITS     1 = slot was blank (all segments off)
//  out_valid  out  1              frame available
//  out_ready  in   1              consumer accepts frame when valid & ready
//  frame_err  out  1              presented frame contains >=1 invalid pattern
//  overrun    out  1              sticky: a digit was dropped because frame buffer was full
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all outputs 0. Input regs, counter, frame buffer, seen mask,
//   and err_pend are cleared. A partial frame is discarded.
//  Decode: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5,
//   0000010->6, 1111000->7, 0000000->8, 0010000->9.
//   1111111 -> code 4'hF, blank=1. Any other pattern -> code 4'hE, invalid.
//  Input stage: seg_in and dig_sel are registered once (seg_q, sel_q). prev_q holds the
//   previous {seg_q, sel_q}.
//  Stability: if {seg_q, sel_q} != prev_q, cnt=0 and armed=1. Otherwise cnt increments,
//   saturating at STABLE_CYCLES-1.
//   Capture pulse fires when cnt==STABLE_CYCLES-1 and armed=1, then armed=0.
//   This gives one capture per stable episode.
//   If sel_q is zero or not one-hot, cnt is held 0 and no capture occurs.
//  Latency: if inputs are constant from edge t, capture occurs at edge t+STABLE_CYCLES.
//  Capture in COLLECT: write code/blank into slot, set seen[i]; invalid sets err_pend.
//   A repeat capture of a seen slot overwrites it (latest wins), with no error.
//  FSM:
//   COLLECT: when seen becomes all ones, move to PENDING at the capture edge.
//   PENDING, output free (!out_valid | out_ready): at the next edge, copy buffer to
//    out_bcd/out_blank, frame_err<=err_pend, out_valid<=1.
//    Also clear seen and err_pend, and return to COLLECT.
//   PENDING, output busy: hold. Any capture is dropped and sets overrun=1 (cleared only by reset).
//  Handshake: once out_valid=1, out_bcd/out_blank/frame_err are stable until the edge with out_ready=1.
//   At that edge out_valid drops, unless a pending frame loads in the same edge
//   (back-to-back, out_valid stays 1).
//  out_ready while out_valid=0 has no effect.
//  Last-digit capture to out_valid=1 is 1 edge when the output is free.
// TESTING
//  1 Scan slot0=0011001, slot1=0110000, slot2=0100100, slot3=1111001, 6 cycles each,
//    ready=1 -> out_bcd=16'h1234, out_blank=0, frame_err=0, out_valid for 1 cycle.
//  2 Hold slot0 pattern 0000000 for only 2 cycles, then switch -> slot0 not captured.
//    No frame until a stable 8 is scanned.
//  3 slot2=1111111, slot1=0101010, others valid -> out_bcd[11:8]=F, out_blank=4'b0100,
//    out_bcd[7:4]=E, frame_err=1.
//  4 ready=0: complete frame A (presented) and frame B (pending), then one more capture.
//    -> overrun=1 and A held stable. Raise ready -> B on out_bcd next edge, out_valid stays 1.
//  5 dig_sel=4'b0011 or 0 held 10 cycles -> no capture, seen unchanged, no out_valid.
//  6 Capture 3 slots, pulse rst_n=0 one cycle, then scan a full new frame.
//    -> only the new frame is presented; all outputs are 0 during reset.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Scanned seven-segment bus plus the decoded-frame valid/ready channel.
// The decoder sits on the slave side; the master drives the scan and the consumer ready.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic [NUM_DIGITS-1:0]   out_blank;
  logic                    out_valid;
  logic                    out_ready;
  logic                    frame_err;
  logic                    overrun;

  modport master (
    output seg_in, dig_sel, out_ready,
    input  out_bcd, out_blank, out_valid, frame_err, overrun
  );

  modport slave (
    input  seg_in, dig_sel, out_ready,
    output out_bcd, out_blank, out_valid, frame_err, overrun
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment scan, filters each digit for stability,
// decodes it to BCD and hands complete frames out over a valid/ready channel.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_decoder_if.slave  bus
);

  typedef enum logic {COLLECT, PENDING} state_t;

  localparam int                SW       = 7 + NUM_DIGITS;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

  state_t                  state_reg;
  logic [6:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   sel_reg;
  logic [SW-1:0]           prev_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    armed_reg;
  logic [4*NUM_DIGITS-1:0] bcd_buf_reg;
  logic [NUM_DIGITS-1:0]   blank_buf_reg;
  logic [NUM_DIGITS-1:0]   seen_reg;
  logic                    err_pend_reg;
  logic [4*NUM_DIGITS-1:0] out_bcd_reg;
  logic [NUM_DIGITS-1:0]   out_blank_reg;
  logic                    out_valid_reg;
  logic                    frame_err_reg;
  logic                    overrun_reg;

  logic                    sel_onehot;
  logic                    same;
  logic                    capture;
  logic                    out_free;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic [3:0]              dec_code;
  logic                    dec_blank;
  logic                    dec_invalid;

  assign sel_onehot = (sel_reg != '0) && ((sel_reg & (sel_reg - 1'b1)) == '0);
  assign same       = ({seg_reg, sel_reg} == prev_reg);
  // Firing on the edge where the counter reaches its top keeps latency at STABLE_CYCLES.
  assign capture    = same && sel_onehot && armed_reg && (cnt_reg == CNT_FIRE);
  assign out_free   = !out_valid_reg || bus.out_ready;
  assign seen_next  = seen_reg | sel_reg;

  always_comb begin
    dec_code    = 4'hE;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (seg_reg)
      7'b1000000: dec_code = 4'd0;
      7'b1111001: dec_code = 4'd1;
      7'b0100100: dec_code = 4'd2;
      7'b0110000: dec_code = 4'd3;
      7'b0011001: dec_code = 4'd4;
      7'b0010010: dec_code = 4'd5;
      7'b0000010: dec_code = 4'd6;
      7'b1111000: dec_code = 4'd7;
      7'b0000000: dec_code = 4'd8;
      7'b0010000: dec_code = 4'd9;
      7'b1111111: begin
        dec_code  = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= COLLECT;
      seg_reg       <= '0;
      sel_reg       <= '0;
      prev_reg      <= '0;
      cnt_reg       <= '0;
      armed_reg     <= 1'b0;
      bcd_buf_reg   <= '0;
      blank_buf_reg <= '0;
      seen_reg      <= '0;
      err_pend_reg  <= 1'b0;
      out_bcd_reg   <= '0;
      out_blank_reg <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      seg_reg  <= bus.seg_in;
      sel_reg  <= bus.dig_sel;
      prev_reg <= {seg_reg, sel_reg};

      if (!same) begin
        cnt_reg   <= '0;
        armed_reg <= 1'b1;
      end else if (!sel_onehot) begin
        cnt_reg <= '0;
      end else begin
        if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
        if (capture) armed_reg <= 1'b0;
      end

      // A frame load below overrides this, giving back-to-back presentation.
      if (bus.out_ready) out_valid_reg <= 1'b0;

      case (state_reg)
        COLLECT: begin
          if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (sel_reg[i]) begin
                bcd_buf_reg[4*i +: 4] <= dec_code;
                blank_buf_reg[i]      <= dec_blank;
              end
            end
            seen_reg     <= seen_next;
            err_pend_reg <= err_pend_reg | dec_invalid;
            if (&seen_next) state_reg <= PENDING;
          end
        end
        PENDING: begin
          if (out_free) begin
            out_bcd_reg   <= bcd_buf_reg;
            out_blank_reg <= blank_buf_reg;
            frame_err_reg <= err_pend_reg;
            out_valid_reg <= 1'b1;
            seen_reg      <= '0;
            err_pend_reg  <= 1'b0;
            state_reg     <= COLLECT;
          end else if (capture) begin
            overrun_reg <= 1'b1;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign bus.out_bcd   = out_bcd_reg;
  assign bus.out_blank = out_blank_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built frames and compares
// the presented frames, flags and handshake timing against fixed expectations.
module tb_seg_scan_decoder;

  localparam int ND = 4;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S6  = 7'b0000010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SBL = 7'b1111111;
  localparam logic [6:0] SBD = 7'b0101010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_decoder #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input int slot, input logic [6:0] seg, input int n);
    bus.dig_sel = ND'(1 << slot);
    bus.seg_in  = seg;
    step(n);
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] bcd,
                              input logic [3:0] blank, input logic err);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_bcd"},   32'(bus.out_bcd),   32'(bcd));
    check_eq({tag, "_blank"}, 32'(bus.out_blank), 32'(blank));
    check_eq({tag, "_err"},   32'(bus.frame_err), 32'(err));
    $display("frame %s: bcd=%h blank=%b err=%b overrun=%b",
             tag, bus.out_bcd, bus.out_blank, bus.frame_err, bus.overrun);
  endtask

  task automatic expect_reset_state(input string tag);
    check_eq({tag, "_valid"},   32'(bus.out_valid), 32'd0);
    check_eq({tag, "_bcd"},     32'(bus.out_bcd),   32'd0);
    check_eq({tag, "_blank"},   32'(bus.out_blank), 32'd0);
    check_eq({tag, "_err"},     32'(bus.frame_err), 32'd0);
    check_eq({tag, "_overrun"}, 32'(bus.overrun),   32'd0);
  endtask

  initial begin
    bus.seg_in    = SBL;
    bus.dig_sel   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    step(3);
    expect_reset_state("rst");
    rst_n = 1'b1;
    step(1);

    // Basic frame; last digit capture to valid is exactly one edge
    scan(0, S4, 6);
    scan(1, S3, 6);
    scan(2, S2, 6);
    scan(3, S1, 5);
    check_eq("t1_pre_valid", 32'(bus.out_valid), 32'd0);
    step(1);
    expect_frame("t1", 16'h1234, 4'b0000, 1'b0);
    step(1);
    check_eq("t1_drop_valid", 32'(bus.out_valid), 32'd0);

    // Too-short digit is never captured
    scan(0, S8, 2);
    scan(1, S5, 6);
    scan(2, S6, 6);
    scan(3, S7, 6);
    check_eq("t2_no_frame", 32'(bus.out_valid), 32'd0);
    scan(0, S8, 6);
    expect_frame("t2", 16'h7658, 4'b0000, 1'b0);
    step(1);

    // Blank and invalid patterns
    scan(0, S0, 6);
    scan(1, SBD, 6);
    scan(2, SBL, 6);
    scan(3, S9, 6);
    expect_frame("t3", 16'h9FE0, 4'b0100, 1'b1);
    step(1);
    check_eq("t3_drop_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A presented, B pending, extra capture overruns
    bus.out_ready = 1'b0;
    scan(0, S1, 6);
    scan(1, S2, 6);
    scan(2, S3, 6);
    scan(3, S4, 6);
    expect_frame("t4a", 16'h4321, 4'b0000, 1'b0);
    scan(0, S5, 6);
    scan(1, S6, 6);
    scan(2, S7, 6);
    scan(3, S8, 6);
    check_eq("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t4_hold_bcd",   32'(bus.out_bcd),   32'h4321);
    check_eq("t4_no_overrun", 32'(bus.overrun),   32'd0);
    scan(0, S9, 6);
    check_eq("t4_overrun",    32'(bus.overrun),   32'd1);
    check_eq("t4_held_bcd",   32'(bus.out_bcd),   32'h4321);
    bus.out_ready = 1'b1;
    step(1);
    expect_frame("t4b", 16'h8765, 4'b0000, 1'b0);
    step(1);
    check_eq("t4_drop_valid", 32'(bus.out_valid), 32'd0);

    // Non-one-hot and empty digit select are ignored
    scan(0, S2, 6);
    scan(1, S4, 6);
    scan(2, S6, 6);
    bus.dig_sel = 4'b0011;
    bus.seg_in  = S1;
    step(10);
    bus.dig_sel = 4'b0000;
    step(10);
    check_eq("t5_no_frame", 32'(bus.out_valid), 32'd0);
    scan(3, S8, 6);
    expect_frame("t5", 16'h8642, 4'b0000, 1'b0);
    check_eq("t5_overrun_sticky", 32'(bus.overrun), 32'd1);
    step(1);

    // Reset mid-frame discards the partial frame
    scan(0, S7, 6);
    scan(1, S7, 6);
    scan(2, S7, 6);
    bus.dig_sel = '0;
    rst_n = 1'b0;
    step(1);
    expect_reset_state("t6_rst");
    rst_n = 1'b1;
    scan(3, S5, 6);
    step(2);
    check_eq("t6_discard", 32'(bus.out_valid), 32'd0);
    scan(0, S1, 6);
    scan(1, S2, 6);
    scan(2, S3, 6);
    expect_frame("t6", 16'h5321, 4'b0000, 1'b0);
    check_eq("t6_overrun", 32'(bus.overrun), 32'd0);
    step(1);
    check_eq("t6_drop_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
